// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard sequencer.
//   state_e  : sequencer FSM states (RUN, LD_STALL, FREEZE, FLUSH)
//   XZR_REG  : register number of the zero register (never a real destination)
//   LD_CNT_W : width of the load-use stall down-counter
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LD_STALL = 2'd1,
      FREEZE   = 2'd2,
      FLUSH    = 2'd3
   } state_e;

   localparam logic [4:0]  XZR_REG  = 5'd31;
   localparam int unsigned LD_CNT_W = 3;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard sequencer bus.
//   master : pipeline side; drives ID/EX usage info, branch resolution and
//            dmem_busy, receives register enables, flush/bubble/redirect,
//            event counters and debug state.
//   slave  : hazard sequencer side (directions reversed).
interface pipeline_hazard_ctrl_if #(
   parameter int unsigned CNT_W = 16
);
   logic             id_valid;
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic             id_uses_rs1;
   logic             id_uses_rs2;
   logic             id_reads_flags;
   logic             ex_valid;
   logic [4:0]       ex_rd;
   logic             ex_RegWrite;
   logic             ex_memToReg;
   logic             ex_set_flags;
   logic             br_taken_ex;
   logic             dmem_busy;

   logic             pc_we;
   logic             ifid_we;
   logic             idex_we;
   logic             exmem_we;
   logic             memwb_we;
   logic             ifid_flush;
   logic             idex_bubble;
   logic             pc_redirect;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
   logic [CNT_W-1:0] freeze_cnt;
   logic [1:0]       state_o;

   modport master (
      output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_reads_flags,
             ex_valid, ex_rd, ex_RegWrite, ex_memToReg, ex_set_flags,
             br_taken_ex, dmem_busy,
      input  pc_we, ifid_we, idex_we, exmem_we, memwb_we,
             ifid_flush, idex_bubble, pc_redirect,
             stall_cnt, flush_cnt, freeze_cnt, state_o
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_reads_flags,
             ex_valid, ex_rd, ex_RegWrite, ex_memToReg, ex_set_flags,
             br_taken_ex, dmem_busy,
      output pc_we, ifid_we, idex_we, exmem_we, memwb_we,
             ifid_flush, idex_bubble, pc_redirect,
             stall_cnt, flush_cnt, freeze_cnt, state_o
   );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter used for performance events.
//   clk   : clock
//   rst   : synchronous active-high reset, clears count
//   inc   : add one this cycle (ignored once count is all-ones)
//   count : current value
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else if (inc && (count_q != '1)) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/freeze sequencer for the 5-stage pipeline.
//   clk, rst : clock, synchronous active-high reset
//   hz       : slave side of the hazard bus; ID/EX usage, branch resolution
//              and dmem_busy in; per-register enables, IF/ID flush, ID/EX
//              bubble, PC redirect, saturating stall/flush/freeze counters
//              and the current FSM state out.
// All control outputs are Mealy: they react in the cycle of detection.
module pipeline_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned CNT_W    = 16
) (
   input logic                  clk,
   input logic                  rst,
   pipeline_hazard_ctrl_if.slave hz
);

   state_e              state_q, state_d;
   state_e              saved_q, saved_d;
   state_e              eff_state;
   logic [LD_CNT_W-1:0] ld_cnt_q, ld_cnt_d;

   logic load_use, flag_use;
   logic stall_inc, flush_inc, freeze_inc;

   logic pc_we, ifid_we, idex_we, exmem_we, memwb_we;
   logic ifid_flush, idex_bubble, pc_redirect;

   assign load_use = hz.id_valid & hz.ex_valid & hz.ex_memToReg & hz.ex_RegWrite &
                     (hz.ex_rd != XZR_REG) &
                     ((hz.id_uses_rs1 & (hz.id_rs1 == hz.ex_rd)) |
                      (hz.id_uses_rs2 & (hz.id_rs2 == hz.ex_rd)));

   assign flag_use = hz.id_valid & hz.id_reads_flags & hz.ex_valid & hz.ex_set_flags;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= RUN;
         saved_q  <= RUN;
         ld_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         saved_q  <= saved_d;
         ld_cnt_q <= ld_cnt_d;
      end
   end

   always_comb begin
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      idex_we     = 1'b1;
      exmem_we    = 1'b1;
      memwb_we    = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      pc_redirect = 1'b0;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
      freeze_inc  = 1'b0;
      state_d     = RUN;
      saved_d     = saved_q;
      ld_cnt_d    = ld_cnt_q;
      // Leaving a freeze decodes as whatever state was interrupted.
      eff_state   = (state_q == FREEZE) ? saved_q : state_q;

      if (rst) begin
         pc_we       = 1'b0;
         ifid_we     = 1'b0;
         idex_we     = 1'b0;
         exmem_we    = 1'b0;
         memwb_we    = 1'b0;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         saved_d     = RUN;
         ld_cnt_d    = '0;
      end else if (hz.dmem_busy) begin
         pc_we      = 1'b0;
         ifid_we    = 1'b0;
         idex_we    = 1'b0;
         exmem_we   = 1'b0;
         memwb_we   = 1'b0;
         freeze_inc = 1'b1;
         state_d    = FREEZE;
         // Consecutive freeze cycles must keep the originally interrupted state.
         if (state_q != FREEZE) begin
            saved_d = state_q;
         end
      end else if (hz.br_taken_ex) begin
         // ID holds a wrong-path instruction, so its hazards are irrelevant.
         pc_redirect = 1'b1;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         flush_inc   = 1'b1;
         ld_cnt_d    = '0;
         state_d     = FLUSH;
      end else if (eff_state == LD_STALL) begin
         pc_we       = 1'b0;
         ifid_we     = 1'b0;
         idex_bubble = 1'b1;
         stall_inc   = 1'b1;
         ld_cnt_d    = (ld_cnt_q != '0) ? ld_cnt_q - 1'b1 : '0;
         state_d     = (ld_cnt_q > LD_CNT_W'(1)) ? LD_STALL : RUN;
      end else if (load_use) begin
         pc_we       = 1'b0;
         ifid_we     = 1'b0;
         idex_bubble = 1'b1;
         stall_inc   = 1'b1;
         if (LOAD_LAT > 1) begin
            ld_cnt_d = LD_CNT_W'(LOAD_LAT - 1);
            state_d  = LD_STALL;
         end
      end else if (flag_use) begin
         pc_we       = 1'b0;
         ifid_we     = 1'b0;
         idex_bubble = 1'b1;
         stall_inc   = 1'b1;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_inc),
      .count (hz.stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush_inc),
      .count (hz.flush_cnt)
   );

   sat_counter #(.W(CNT_W)) u_freeze_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (freeze_inc),
      .count (hz.freeze_cnt)
   );

   assign hz.pc_we       = pc_we;
   assign hz.ifid_we     = ifid_we;
   assign hz.idex_we     = idex_we;
   assign hz.exmem_we    = exmem_we;
   assign hz.memwb_we    = memwb_we;
   assign hz.ifid_flush  = ifid_flush;
   assign hz.idex_bubble = idex_bubble;
   assign hz.pc_redirect = pc_redirect;
   assign hz.state_o     = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Two sequencers driven with identical stimulus: dut_a (LOAD_LAT=1,
// 16-bit counters) and dut_b (LOAD_LAT=3, 4-bit counters so saturation
// is reached quickly).
module tb_pipeline_hazard_ctrl;
   import hazard_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pipeline_hazard_ctrl_if #(.CNT_W(16)) if_a ();
   pipeline_hazard_ctrl_if #(.CNT_W(4))  if_b ();

   pipeline_hazard_ctrl #(.LOAD_LAT(1), .CNT_W(16)) dut_a (
      .clk (clk),
      .rst (rst),
      .hz  (if_a)
   );

   pipeline_hazard_ctrl #(.LOAD_LAT(3), .CNT_W(4)) dut_b (
      .clk (clk),
      .rst (rst),
      .hz  (if_b)
   );

   typedef struct packed {
      logic       rst;
      logic       busy;
      logic       br;
      logic       id_valid;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic       rf;
      logic       ex_valid;
      logic [4:0] rd;
      logic       rw;
      logic       m2r;
      logic       sf;
   } stim_t;

   // ctl = {pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_bubble, pc_redirect}
   typedef struct packed {
      logic [7:0]  ctl;
      logic [1:0]  st;
      logic [15:0] sc;
      logic [15:0] fc;
      logic [15:0] zc;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: remaining forced stall cycles, state shown on state_o,
   // event counts.
   int     m_rem [2];
   state_e m_st  [2];
   int     m_sc  [2];
   int     m_fc  [2];
   int     m_zc  [2];
   int     busy_left = 0;

   function automatic stim_t quiet();
      stim_t s;
      s = '0;
      s.id_valid = 1'b1;
      s.rs1 = 5'd4;  s.u1 = 1'b1;
      s.rs2 = 5'd5;  s.u2 = 1'b1;
      s.ex_valid = 1'b1;
      s.rd = 5'd6;   s.rw = 1'b1;
      return s;
   endfunction

   function automatic logic [4:0] pick_reg();
      case ($urandom_range(0, 4))
         0: return 5'd1;
         1: return 5'd2;
         2: return 5'd3;
         3: return 5'd31;
         default: return 5'($urandom_range(0, 31));
      endcase
   endfunction

   task automatic model(input int k, input stim_t s, output exp_t e);
      int  ll, mx;
      bit  lu, fu;
      ll = (k == 0) ? 1 : 3;
      mx = (k == 0) ? 65535 : 15;
      lu = s.id_valid && s.ex_valid && s.m2r && s.rw && (s.rd != 5'd31) &&
           ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
      fu = s.id_valid && s.rf && s.ex_valid && s.sf;
      e.st = m_st[k];
      e.sc = 16'(m_sc[k]);
      e.fc = 16'(m_fc[k]);
      e.zc = 16'(m_zc[k]);
      if (s.rst) begin
         e.ctl = 8'b00000_110;
         m_rem[k] = 0; m_st[k] = RUN;
         m_sc[k] = 0; m_fc[k] = 0; m_zc[k] = 0;
      end else if (s.busy) begin
         e.ctl = 8'b00000_000;
         m_st[k] = FREEZE;
         if (m_zc[k] < mx) m_zc[k]++;
      end else if (s.br) begin
         e.ctl = 8'b11111_111;
         m_rem[k] = 0;
         m_st[k] = FLUSH;
         if (m_fc[k] < mx) m_fc[k]++;
      end else if (m_rem[k] > 0 || lu || fu) begin
         e.ctl = 8'b00111_010;
         if (m_rem[k] > 0) m_rem[k]--;
         else if (lu) m_rem[k] = ll - 1;
         m_st[k] = (m_rem[k] > 0) ? LD_STALL : RUN;
         if (m_sc[k] < mx) m_sc[k]++;
      end else begin
         e.ctl = 8'b11111_000;
         m_st[k] = RUN;
      end
   endtask

   task automatic drive(input stim_t s);
      rst = s.rst;
      if_a.dmem_busy = s.busy;      if_b.dmem_busy = s.busy;
      if_a.br_taken_ex = s.br;      if_b.br_taken_ex = s.br;
      if_a.id_valid = s.id_valid;   if_b.id_valid = s.id_valid;
      if_a.id_rs1 = s.rs1;          if_b.id_rs1 = s.rs1;
      if_a.id_rs2 = s.rs2;          if_b.id_rs2 = s.rs2;
      if_a.id_uses_rs1 = s.u1;      if_b.id_uses_rs1 = s.u1;
      if_a.id_uses_rs2 = s.u2;      if_b.id_uses_rs2 = s.u2;
      if_a.id_reads_flags = s.rf;   if_b.id_reads_flags = s.rf;
      if_a.ex_valid = s.ex_valid;   if_b.ex_valid = s.ex_valid;
      if_a.ex_rd = s.rd;            if_b.ex_rd = s.rd;
      if_a.ex_RegWrite = s.rw;      if_b.ex_RegWrite = s.rw;
      if_a.ex_memToReg = s.m2r;     if_b.ex_memToReg = s.m2r;
      if_a.ex_set_flags = s.sf;     if_b.ex_set_flags = s.sf;
   endtask

   task automatic apply(input stim_t s);
      exp_t ea, eb;
      @(posedge clk);
      #1;
      drive(s);
      model(0, s, ea);
      model(1, s, eb);
      qa.push_back(ea);
      qb.push_back(eb);
   endtask

   function automatic stim_t rand_stim();
      stim_t s;
      s.rst      = ($urandom_range(0, 299) == 0);
      if (busy_left == 0 && $urandom_range(0, 9) == 0) busy_left = $urandom_range(1, 5);
      s.busy     = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      s.br       = ($urandom_range(0, 11) == 0);
      s.id_valid = ($urandom_range(0, 9) != 0);
      s.rs1      = pick_reg();
      s.rs2      = pick_reg();
      s.u1       = ($urandom_range(0, 9) < 7);
      s.u2       = ($urandom_range(0, 9) < 6);
      s.rf       = ($urandom_range(0, 4) == 0);
      s.ex_valid = ($urandom_range(0, 9) != 0);
      s.rd       = pick_reg();
      s.rw       = ($urandom_range(0, 9) < 7);
      s.m2r      = ($urandom_range(0, 9) < 4);
      s.sf       = ($urandom_range(0, 9) < 3);
      return s;
   endfunction

   task automatic chk(input int k, input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d at %0t: got %h expected %h", nm, k, $time, act, exp);
      end
   endtask

   // Monitor: outputs are sampled mid-cycle, away from the rising edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (qa.size() > 0) begin
            e = qa.pop_front();
            chk(0, "ctl", {8'h0, if_a.pc_we, if_a.ifid_we, if_a.idex_we, if_a.exmem_we,
                           if_a.memwb_we, if_a.ifid_flush, if_a.idex_bubble, if_a.pc_redirect},
                {8'h0, e.ctl});
            chk(0, "state", {14'h0, if_a.state_o}, {14'h0, e.st});
            chk(0, "stall_cnt",  if_a.stall_cnt,  e.sc);
            chk(0, "flush_cnt",  if_a.flush_cnt,  e.fc);
            chk(0, "freeze_cnt", if_a.freeze_cnt, e.zc);
         end
         if (qb.size() > 0) begin
            e = qb.pop_front();
            chk(1, "ctl", {8'h0, if_b.pc_we, if_b.ifid_we, if_b.idex_we, if_b.exmem_we,
                           if_b.memwb_we, if_b.ifid_flush, if_b.idex_bubble, if_b.pc_redirect},
                {8'h0, e.ctl});
            chk(1, "state", {14'h0, if_b.state_o}, {14'h0, e.st});
            chk(1, "stall_cnt",  {12'h0, if_b.stall_cnt},  e.sc);
            chk(1, "flush_cnt",  {12'h0, if_b.flush_cnt},  e.fc);
            chk(1, "freeze_cnt", {12'h0, if_b.freeze_cnt}, e.zc);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      stim_t s;
      for (int k = 0; k < 2; k++) begin
         m_rem[k] = 0; m_st[k] = RUN; m_sc[k] = 0; m_fc[k] = 0; m_zc[k] = 0;
      end
      s = quiet();
      s.rst = 1'b1;
      drive(s);
      apply(s);
      apply(s);

      // Load into X2 followed by a consumer of X2.
      s = quiet(); s.rd = 5'd2; s.m2r = 1'b1; s.rs1 = 5'd2;
      apply(s);
      repeat (3) apply(quiet());
      // Flag producer in EX, B.cond in ID.
      s = quiet(); s.sf = 1'b1; s.rf = 1'b1;
      apply(s);
      // Load to XZR with a reader of X31: no stall.
      s = quiet(); s.rd = 5'd31; s.m2r = 1'b1; s.rs1 = 5'd31;
      apply(s);
      // Taken branch coinciding with a load-use.
      s = quiet(); s.rd = 5'd2; s.m2r = 1'b1; s.rs2 = 5'd2; s.br = 1'b1;
      apply(s);
      apply(quiet());
      // Freeze in the middle of a multi-cycle load stall.
      s = quiet(); s.rd = 5'd3; s.m2r = 1'b1; s.rs1 = 5'd3;
      apply(s);
      apply(quiet());
      s = quiet(); s.busy = 1'b1;
      repeat (4) apply(s);
      repeat (2) apply(quiet());
      // Reset while frozen.
      s = quiet(); s.busy = 1'b1;
      repeat (2) apply(s);
      s.rst = 1'b1;
      apply(s);
      apply(quiet());

      repeat (3000) apply(rand_stim());

      @(posedge clk);
      @(negedge clk);
      #1;
      n_cmp++;
      if (qa.size() != 0 || qb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d/%0d expected entries left, required 0/0", qa.size(), qb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Stall/flush/freeze sequencer for the 5-stage pipeline. It sits beside the decode control unit. From ID-stage register usage, EX-stage destination and flag info, EX-stage branch resolution and a data-memory busy signal, it decides each cycle whether to advance, hold, bubble or flush each pipeline register. It also keeps saturating performance counters for stalls, flushes and freezes.

## Interface
- LOAD_LAT, 1: load-use stall cycles (1..7).
- CNT_W, 16: performance counter width.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  5 each  ID source register numbers (Rn, Reg2Loc-selected Rm/Rt).
- id_uses_rs1, id_uses_rs2  in  1 each  ID actually reads that source.
- id_reads_flags  in  1  ID is B.cond.
- ex_valid  in  1  EX holds a real instruction.
- ex_rd  in  5  EX destination register.
- ex_RegWrite, ex_memToReg, ex_set_flags  in  1 each  EX control bits.
- br_taken_ex  in  1  branch in EX resolved taken (PC redirect this cycle).
- dmem_busy  in  1  data memory not ready; freeze the whole pipeline.
- pc_we, ifid_we, idex_we, exmem_we, memwb_we  out  1 each  register enables.
- ifid_flush  out  1  load NOP into IF/ID.
- idex_bubble  out  1  load NOP (all control 0) into ID/EX.
- pc_redirect  out  1  PC takes branch target.
- stall_cnt, flush_cnt, freeze_cnt  out  CNT_W each  saturating event counters.
- state_o  out  2  current FSM state, for debug.

## Operation
- FSM states are RUN, LD_STALL, FREEZE and FLUSH.
- LD_STALL holds a down-counter ld_cnt, 3 bits.
- Hazard terms are combinational:
  - load_use = id_valid & ex_valid & ex_memToReg & ex_RegWrite & ex_rd!=31 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - flag_use = id_valid & id_reads_flags & ex_valid & ex_set_flags.
- Priority, highest first: rst, then dmem_busy, then br_taken_ex, then LD_STALL continuation, then load_use, then flag_use.
- Freeze (dmem_busy=1):
  - All five enables are 0. ifid_flush, idex_bubble and pc_redirect are 0.
  - The previous state is saved and ld_cnt is held.
  - Next state is FREEZE. When dmem_busy falls, the saved state resumes.
  - A branch in EX is still present after a freeze, so it is acted on then; no pending latch is needed.
- Flush (br_taken_ex=1, not frozen):
  - pc_redirect=1, ifid_flush=1, idex_bubble=1.
  - pc_we, exmem_we and memwb_we are 1.
  - Any load_use or flag_use is ignored, because the ID instruction is wrong-path.
  - ld_cnt is cleared. Next state is FLUSH for exactly one cycle, then RUN. In FLUSH, outputs are normal RUN decoding.
- Load-use (in RUN):
  - pc_we=0, ifid_we=0, idex_bubble=1. All later stages enabled.
  - If LOAD_LAT>1: ld_cnt←LOAD_LAT-1, next state LD_STALL.
  - In LD_STALL: same outputs, ld_cnt decrements each unfrozen cycle, and the state returns to RUN when ld_cnt reaches 0 after that cycle's stall.
- Flag-use: one-cycle stall with the same outputs as load-use. State stays RUN.
- No hazard: all enables 1, no flush, no bubble.
- Counters (each saturates at all-ones, never wraps):
  - stall_cnt +1 per cycle of load-use, LD_STALL or flag stall.
  - flush_cnt +1 per flush cycle.
  - freeze_cnt +1 per freeze cycle.

## Timing
- Stall, flush and freeze outputs are Mealy outputs, asserted in the same cycle as detection (zero latency).
- State and counters update on the clk rising edge.
- Load-use costs LOAD_LAT bubble cycles. Flag-use costs 1. A taken branch costs 2 wrong-path slots (IF/ID and ID/EX) with no stall.
- Reset, while rst=1:
  - Outputs: all enables 0, ifid_flush=1, idex_bubble=1, pc_redirect=0.
  - After the edge: state RUN, ld_cnt=0, counters 0.
- A reset mid-LD_STALL or mid-FREEZE aborts it. The first cycle after rst falls is RUN decoding.
- dmem_busy asserted in the same cycle as a load_use: freeze wins, and the load-use is re-evaluated once busy drops.
- An instruction with ex_rd=31 (XZR) never causes a load-use stall.

## Structure
- Shared package hazard_pkg holds:
  - the state enum (RUN, LD_STALL, FREEZE, FLUSH)
  - XZR_REG = 5'd31
  - an ld_cnt width constant.
- Sub-module sat_counter (parameter W) with inputs clk, rst and inc, and output count. It is instantiated three times.

## Test plan
- LDUR X2 in EX, ADDS reading X2 in ID, LOAD_LAT=1 → one cycle with pc_we=0, ifid_we=0, idex_bubble=1; stall_cnt=1.
- Same case with LOAD_LAT=3 → three consecutive bubble cycles, state_o LD_STALL for 2 of them, then RUN; stall_cnt=3.
- SUBS in EX, B.cond in ID → single stall cycle. ADDS writing X31 from a load → no stall.
- br_taken_ex=1 together with load_use=1 → pc_redirect=1, ifid_flush=1, idex_bubble=1, pc_we=1; flush_cnt=1, stall_cnt unchanged.
- dmem_busy for 4 cycles during LD_STALL with ld_cnt=1 → all enables 0 for 4 cycles; ld_cnt held; freeze_cnt=4; one stall cycle remains afterward.
- rst pulse mid-FREEZE, then counters preloaded near saturation → state RUN and counters 0 after reset; a counter at 0xFFFF stays at 0xFFFF on further events.
